// File: rtl/rsp_s2_pkg.sv
// Shared definitions for the RSP S2 prep chain: lane geometry, estimate FSM states
// and the 17-to-16 bit saturation helper.
package rsp_s2_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned EST_WIDTH  = 2 * DATA_WIDTH;
  localparam int unsigned LANES_C    = 4;
  localparam int unsigned LANES_R    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  // Clamp a sign-extended difference back into the lane range.
  function automatic logic [DATA_WIDTH-1:0] sat16(input logic [DATA_WIDTH:0] d);
    if (d[DATA_WIDTH] != d[DATA_WIDTH-1]) begin
      return d[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
    return d[DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/dc_sub_lane.sv
// One lane of DC removal: S1 registers the 17-bit difference, S2 registers the
// saturated result; clip_c flags that the S1 difference is out of range.
module dc_sub_lane
  import rsp_s2_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s1_en,
  input  logic                  s2_en,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] est,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  clip_c
);

  logic [DATA_WIDTH:0] diff_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q <= '0;
    end else if (s1_en) begin
      diff_q <= {x[DATA_WIDTH-1], x} - {est[DATA_WIDTH-1], est};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y <= '0;
    end else if (s2_en) begin
      y <= sat16(diff_q);
    end
  end

  assign clip_c = diff_q[DATA_WIDTH] != diff_q[DATA_WIDTH-1];

endmodule

// File: rtl/dc_compensation.sv
// Subtracts a frame-synchronous DC estimate from the 128-bit sample stream with a
// 2-cycle pipeline, lane saturation and a saturating clip counter.
module dc_compensation
  import rsp_s2_pkg::*;
#(
  parameter int unsigned READ_RAM_WIDTH = 128,
  parameter int unsigned SATCNT_WIDTH   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_switch,
  input  logic                      i_bypass,
  input  logic [EST_WIDTH-1:0]      i_dc_est,
  input  logic                      i_dc_est_valid,
  input  logic [READ_RAM_WIDTH-1:0] i_x0_data,
  input  logic                      i_x0_valid,
  input  logic                      i_x0_last,
  output logic [READ_RAM_WIDTH-1:0] o_y0_data,
  output logic                      o_y0_valid,
  output logic                      o_y0_last,
  output logic                      o_est_active,
  output logic [SATCNT_WIDTH-1:0]   o_sat_cnt
);

  localparam int unsigned LANES = READ_RAM_WIDTH / DATA_WIDTH;
  localparam int unsigned SUM_W = $clog2(LANES + 1);
  localparam int unsigned CNT_W = SATCNT_WIDTH + 1;

  state_e               state_q, state_d;
  logic [EST_WIDTH-1:0] shadow_q, shadow_d;
  logic [EST_WIDTH-1:0] active_q, active_d;
  logic                 mode_q, mode_d;
  logic                 s1_valid_q, s1_last_q;
  logic [LANES-1:0]     clip_c;
  logic [SUM_W-1:0]     clip_sum_c;
  logic [CNT_W-1:0]     cnt_sum_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      active_q     <= '0;
      mode_q       <= 1'b0;
      o_est_active <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      mode_q       <= mode_d;
      o_est_active <= state_d != IDLE;
    end
  end

  // Estimate double-buffer: commits only on a last beat while pending, and a
  // strobe coinciding with that last beat defers the commit to the next frame.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    mode_d   = mode_q;
    case (state_q)
      IDLE: begin
        if (i_dc_est_valid) begin
          shadow_d = i_dc_est;
          active_d = i_dc_est;
          mode_d   = i_switch;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (i_dc_est_valid) begin
          shadow_d = i_dc_est;
          state_d  = PEND;
        end
      end
      PEND: begin
        if (i_dc_est_valid) begin
          shadow_d = i_dc_est;
        end else if (i_x0_valid && i_x0_last) begin
          active_d = shadow_q;
          mode_d   = i_switch;
          state_d  = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [DATA_WIDTH-1:0] est_lane;

    always_comb begin
      if (i_bypass) begin
        est_lane = '0;
      end else if (mode_q || (g % 2 == 0)) begin
        est_lane = active_q[DATA_WIDTH-1:0];
      end else begin
        est_lane = active_q[EST_WIDTH-1:DATA_WIDTH];
      end
    end

    dc_sub_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .s1_en  (i_x0_valid),
      .s2_en  (s1_valid_q),
      .x      (i_x0_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .est    (est_lane),
      .y      (o_y0_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .clip_c (clip_c[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      o_y0_valid <= 1'b0;
      o_y0_last  <= 1'b0;
    end else begin
      s1_valid_q <= i_x0_valid;
      s1_last_q  <= i_x0_valid & i_x0_last;
      o_y0_valid <= s1_valid_q;
      o_y0_last  <= s1_last_q;
    end
  end

  always_comb begin
    clip_sum_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      clip_sum_c = clip_sum_c + SUM_W'(clip_c[i]);
    end
    cnt_sum_c = CNT_W'(o_sat_cnt) + CNT_W'(clip_sum_c);
  end

  // Counter holds at all-ones once the sum overflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_sat_cnt <= '0;
    end else if (s1_valid_q) begin
      o_sat_cnt <= cnt_sum_c[SATCNT_WIDTH] ? '1 : cnt_sum_c[SATCNT_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_dc_compensation.sv
// Directed plus random bench for dc_compensation with an arithmetic reference model.
module tb_dc_compensation;

  logic         clk = 1'b0;
  logic         rst, i_switch, i_bypass, i_dc_est_valid, i_x0_valid, i_x0_last;
  logic [31:0]  i_dc_est;
  logic [127:0] i_x0_data;
  logic [127:0] o_y0_data;
  logic         o_y0_valid, o_y0_last, o_est_active;
  logic [15:0]  o_sat_cnt;

  int errors = 0;
  int checks = 0;

  // reference model: estimate bookkeeping
  bit          m_has, m_pend, m_mode;
  logic [31:0] m_act, m_shd;
  // reference model: one beat in flight plus expected outputs
  bit           s1_v, s1_l;
  logic [127:0] s1_d;
  int           s1_clips;
  logic [127:0] e_data;
  bit           e_v, e_l, e_act;
  int           e_cnt;

  dc_compensation dut (
    .clk(clk), .rst(rst), .i_switch(i_switch), .i_bypass(i_bypass),
    .i_dc_est(i_dc_est), .i_dc_est_valid(i_dc_est_valid),
    .i_x0_data(i_x0_data), .i_x0_valid(i_x0_valid), .i_x0_last(i_x0_last),
    .o_y0_data(o_y0_data), .o_y0_valid(o_y0_valid), .o_y0_last(o_y0_last),
    .o_est_active(o_est_active), .o_sat_cnt(o_sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void lane_calc(input logic [127:0] x, input logic [31:0] est, input bit mode,
                                    input bit byp, output logic [127:0] y, output int clips);
    clips = 0;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      logic [15:0] el;
      int xv, ev, d;
      el = mode ? est[15:0] : ((i % 2 == 0) ? est[15:0] : est[31:16]);
      xv = int'($signed(x[i*16 +: 16]));
      ev = byp ? 0 : int'($signed(el));
      d = xv - ev;
      if (d > 32767) begin d = 32767; clips++; end
      else if (d < -32768) begin d = -32768; clips++; end
      y[i*16 +: 16] = 16'(d);
    end
  endfunction

  task automatic step(input bit r, input bit v, input bit l, input logic [127:0] d,
                      input bit ev, input logic [31:0] e, input bit sw, input bit byp);
    rst = r; i_x0_valid = v; i_x0_last = l; i_x0_data = d;
    i_dc_est_valid = ev; i_dc_est = e; i_switch = sw; i_bypass = byp;
    if (r) begin
      m_has = 0; m_pend = 0; m_mode = 0; m_act = '0; m_shd = '0;
      s1_v = 0; s1_l = 0; s1_d = '0; s1_clips = 0;
      e_data = '0; e_v = 0; e_l = 0; e_cnt = 0;
    end else begin
      if (s1_v) begin
        e_data = s1_d;
        e_cnt  = e_cnt + s1_clips;
        if (e_cnt > 65535) e_cnt = 65535;
      end
      e_v = s1_v; e_l = s1_l;
      s1_v = v; s1_l = v && l;
      if (v) lane_calc(d, m_act, m_mode, byp, s1_d, s1_clips);
      if (!m_has) begin
        if (ev) begin m_act = e; m_shd = e; m_mode = sw; m_has = 1; end
      end else if (!m_pend) begin
        if (ev) begin m_shd = e; m_pend = 1; end
      end else if (ev) begin
        m_shd = e;
      end else if (v && l) begin
        m_act = m_shd; m_mode = sw; m_pend = 0;
      end
    end
    e_act = m_has;
    @(posedge clk); #1;
    chk("y_valid", 128'(o_y0_valid), 128'(e_v));
    chk("y_last", 128'(o_y0_last), 128'(e_l));
    chk("y_data", o_y0_data, e_data);
    chk("sat_cnt", 128'(o_sat_cnt), 128'(e_cnt));
    chk("est_active", 128'(o_est_active), 128'(e_act));
  endtask

  task automatic idle(input int n, input bit sw);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, '0, sw, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, '0, 0, '0, 0, 0);
    step(1, 0, 0, '0, 0, '0, 0, 0);
  endtask

  task automatic frame(input int n, input logic [127:0] d, input bit sw);
    for (int i = 0; i < n; i++) step(0, 1, i == n - 1, d, 0, '0, sw, 0);
  endtask

  function automatic logic [127:0] rand_data();
    logic [127:0] d;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 4))
        0: d[i*16 +: 16] = 16'h7FFF;
        1: d[i*16 +: 16] = 16'h8000;
        default: d[i*16 +: 16] = 16'($urandom);
      endcase
    end
    return d;
  endfunction

  logic [127:0] ramp, c100, neg32000, min16;

  initial begin
    for (int i = 0; i < 8; i++) ramp[i*16 +: 16] = 16'(i);
    c100     = {8{16'd100}};
    neg32000 = {8{16'h8300}};
    min16    = {8{16'h8000}};

    // reset, no estimate: real-mode ramp passes through unchanged
    do_reset();
    chk("reset_data", o_y0_data, '0);
    chk("reset_cnt", 128'(o_sat_cnt), '0);
    for (int i = 0; i < 8; i++) step(0, 1, i == 7, ramp, 0, '0, 1, 0);
    idle(1, 1);
    chk("ramp_passthru", o_y0_data, ramp);
    chk("ramp_no_est", 128'(o_est_active), '0);

    // complex mode, I est = -16, Q est = +16
    do_reset();
    step(0, 0, 0, '0, 1, {16'h0010, 16'hFFF0}, 0, 0);
    frame(2, c100, 0);
    idle(1, 0);
    chk("cplx_iq", o_y0_data, {4{16'd84, 16'd116}});

    // real mode negative clip, 8 clips per beat, then bypass leaves data and count alone
    do_reset();
    step(0, 0, 0, '0, 1, 32'd1000, 1, 0);
    frame(3, neg32000, 1);
    idle(1, 1);
    chk("clip_neg", o_y0_data, min16);
    chk("clip_cnt24", 128'(o_sat_cnt), 128'(24));
    step(0, 1, 0, neg32000, 0, '0, 1, 1);
    step(0, 1, 1, neg32000, 0, '0, 1, 1);
    idle(1, 1);
    chk("bypass_data", o_y0_data, neg32000);
    chk("bypass_cnt", 128'(o_sat_cnt), 128'(24));

    // new estimate mid-frame takes effect on the next frame
    do_reset();
    step(0, 0, 0, '0, 1, 32'd5, 1, 0);
    step(0, 1, 0, c100, 0, '0, 1, 0);
    step(0, 1, 0, c100, 1, 32'd9, 1, 0);
    step(0, 1, 0, c100, 0, '0, 1, 0);
    step(0, 1, 1, c100, 0, '0, 1, 0);
    idle(1, 1);
    chk("run_old_est", o_y0_data, {8{16'd95}});
    frame(4, c100, 1);
    idle(1, 1);
    chk("run_new_est", o_y0_data, {8{16'd91}});

    // strobe on the last beat while pending defers the commit one frame
    do_reset();
    step(0, 0, 0, '0, 1, 32'd5, 1, 0);
    step(0, 1, 0, c100, 0, '0, 1, 0);
    step(0, 1, 0, c100, 1, 32'd9, 1, 0);
    step(0, 1, 0, c100, 0, '0, 1, 0);
    step(0, 1, 1, c100, 1, 32'd13, 1, 0);
    idle(1, 1);
    chk("pend_cur", o_y0_data, {8{16'd95}});
    frame(4, c100, 1);
    idle(1, 1);
    chk("pend_next", o_y0_data, {8{16'd95}});
    frame(4, c100, 1);
    idle(1, 1);
    chk("pend_after", o_y0_data, {8{16'd87}});

    // reset mid-frame flushes everything; later frame is unmodified until an estimate
    do_reset();
    step(0, 0, 0, '0, 1, 32'd5, 1, 0);
    step(0, 1, 0, c100, 0, '0, 1, 0);
    step(0, 1, 0, c100, 0, '0, 1, 0);
    step(1, 1, 0, c100, 0, '0, 1, 0);
    chk("rst_mid_valid", 128'(o_y0_valid), '0);
    chk("rst_mid_data", o_y0_data, '0);
    chk("rst_mid_active", 128'(o_est_active), '0);
    frame(3, c100, 1);
    idle(1, 1);
    chk("rst_mid_passthru", o_y0_data, c100);
    step(0, 0, 0, '0, 1, 32'd7, 1, 0);
    frame(1, c100, 1);
    idle(1, 1);
    chk("rst_mid_new_est", o_y0_data, {8{16'd93}});

    // counter saturates at its maximum
    do_reset();
    step(0, 0, 0, '0, 1, 32'd1000, 1, 0);
    for (int i = 0; i < 8200; i++) step(0, 1, (i % 16) == 15, min16, 0, '0, 1, 0);
    idle(2, 1);
    chk("sat_max", 128'(o_sat_cnt), 128'(16'hFFFF));

    // random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           rand_data(), $urandom_range(0, 9) == 0, $urandom, 1'($urandom), $urandom_range(0, 7) == 0);
    end
    idle(2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
